// File: rtl/sync_fifo.sv
// Single-clock FIFO with a register-array store, binary pointers and an
// occupancy counter. Read data is registered and qualified by rd_valid.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  // Handshake: a write is taken when wr_en is high and there is room, or a
  // read leaves the FIFO on the same edge; a read is taken when rd_en is
  // high and the FIFO is not empty. The requester sees no ready signal;
  // refused requests are reported one cycle later on overflow/underflow.

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_acc;
  logic             rd_acc;

  // Flags come only from the registered count, so no request input reaches
  // an output combinationally.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = wr_en & full & ~rd_acc;
    underflow_d = rd_en & empty;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign count     = count_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int W = 8;
  localparam int D = 16;

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         full;
  logic         rd_en;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         empty;
  logic [4:0]   count;
  logic         overflow;
  logic         underflow;

  sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_data;
  logic         exp_valid;
  logic         exp_ovf;
  logic         exp_unf;
  int           n_checks;
  int           n_pass;

  task automatic model_reset();
    exp_q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  // One clock of stimulus; afterwards the model holds what the outputs must be.
  task automatic cycle(input logic we, input logic [W-1:0] wd, input logic re);
    int  n;
    bit  r_ok;
    bit  w_ok;
    n    = exp_q.size();
    r_ok = re && (n > 0);
    w_ok = we && ((n < D) || r_ok);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    exp_valid = r_ok;
    exp_ovf   = we && (n == D) && !r_ok;
    exp_unf   = re && (n == 0);
    if (r_ok) exp_data = exp_q.pop_front();
    if (w_ok) exp_q.push_back(wd);
  endtask

  task automatic drain_all();
    while (exp_q.size() > 0) begin
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_data)
        $display("FAIL drain_data got v=%0b d=%02h exp v=1 d=%02h", rd_valid, rd_data, exp_data);
      else n_pass++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00)
      $display("FAIL reset_state got c=%0d e=%0b f=%0b v=%0b d=%02h exp c=0 e=1 f=0 v=0 d=00",
               count, empty, full, rd_valid, rd_data);
    else n_pass++;
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < D; i++) begin
      cycle(1'b1, W'(i), 1'b0);
      n_checks++;
      if (count !== 5'(i + 1))
        $display("FAIL fill_count got %0d exp %0d", count, i + 1);
      else n_pass++;
    end
    n_checks++;
    if (full !== 1'b1) $display("FAIL fill_full got %0b exp 1", full);
    else n_pass++;
    for (int i = 0; i < D; i++) begin
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== W'(i) || rd_data !== exp_data)
        $display("FAIL drain_order got v=%0b d=%02h exp v=1 d=%02h", rd_valid, rd_data, i);
      else n_pass++;
    end
    cycle(1'b0, '0, 1'b0);
    n_checks++;
    if (empty !== 1'b1 || count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 8'h0F)
      $display("FAIL drain_end got e=%0b c=%0d v=%0b d=%02h exp e=1 c=0 v=0 d=0f",
               empty, count, rd_valid, rd_data);
    else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < D; i++) cycle(1'b1, W'($urandom_range(0, 8'hA9)), 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || exp_ovf !== 1'b1)
      $display("FAIL ovf_pulse got %0b exp 1", overflow);
    else n_pass++;
    n_checks++;
    if (count !== 5'd16 || full !== 1'b1)
      $display("FAIL ovf_count got c=%0d f=%0b exp c=16 f=1", count, full);
    else n_pass++;
    cycle(1'b0, '0, 1'b0);
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_one_cycle got %0b exp 0", overflow);
    else n_pass++;
    for (int i = 0; i < D; i++) begin
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (rd_data === 8'hAA || rd_data !== exp_data || rd_valid !== 1'b1)
        $display("FAIL ovf_drain got %02h exp %02h", rd_data, exp_data);
      else n_pass++;
    end
  endtask

  task automatic test_underflow_simul();
    cycle(1'b1, 8'h55, 1'b1);
    n_checks++;
    if (underflow !== 1'b1 || count !== 5'd1 || rd_valid !== 1'b0)
      $display("FAIL unf_simul got u=%0b c=%0d v=%0b exp u=1 c=1 v=0", underflow, count, rd_valid);
    else n_pass++;
    cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (rd_data !== 8'h55 || rd_valid !== 1'b1 || underflow !== 1'b0)
      $display("FAIL unf_next_read got d=%02h v=%0b u=%0b exp d=55 v=1 u=0", rd_data, rd_valid, underflow);
    else n_pass++;
    cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h55)
      $display("FAIL unf_empty_read got u=%0b v=%0b d=%02h exp u=1 v=0 d=55", underflow, rd_valid, rd_data);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < D; i++) cycle(1'b1, W'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, W'(8'h10 + i), 1'b1);
      n_checks++;
      if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0)
        $display("FAIL wrap_count got c=%0d f=%0b o=%0b exp c=16 f=1 o=0", count, full, overflow);
      else n_pass++;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== W'(i))
        $display("FAIL wrap_data got v=%0b d=%02h exp v=1 d=%02h", rd_valid, rd_data, i);
      else n_pass++;
    end
    drain_all();
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 7; i++) cycle(1'b1, W'($urandom), 1'b0);
    n_checks++;
    if (count !== 5'd7) $display("FAIL mid_pre_count got %0d exp 7", count);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (count !== 5'd0 || empty !== 1'b1)
      $display("FAIL mid_reset got c=%0d e=%0b exp c=0 e=1", count, empty);
    else n_pass++;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'h77, 1'b0);
    cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (rd_data !== 8'h77 || rd_valid !== 1'b1)
      $display("FAIL mid_after got d=%02h v=%0b exp d=77 v=1", rd_data, rd_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    int wr_pct;
    int rd_pct;
    for (int i = 0; i < 600; i++) begin
      wr_pct = (i < 200) ? 80 : (i < 400) ? 50 : 20;
      rd_pct = (i < 200) ? 30 : (i < 400) ? 50 : 80;
      cycle($urandom_range(0, 99) < wr_pct, W'($urandom), $urandom_range(0, 99) < rd_pct);
      n_checks++;
      if (count !== 5'(exp_q.size()) || full !== (exp_q.size() == D) || empty !== (exp_q.size() == 0))
        $display("FAIL rand_occ got c=%0d f=%0b e=%0b exp c=%0d", count, full, empty, exp_q.size());
      else n_pass++;
      n_checks++;
      if (rd_valid !== exp_valid || rd_data !== exp_data)
        $display("FAIL rand_read got v=%0b d=%02h exp v=%0b d=%02h", rd_valid, rd_data, exp_valid, exp_data);
      else n_pass++;
      n_checks++;
      if (overflow !== exp_ovf || underflow !== exp_unf)
        $display("FAIL rand_flags got o=%0b u=%0b exp o=%0b u=%0b", overflow, underflow, exp_ovf, exp_unf);
      else n_pass++;
    end
    drain_all();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;
    model_reset();
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow_simul();
    test_full_wrap();
    test_reset_mid_burst();
    test_random();
    test_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
